// File: rtl/mode_pkg.sv
// rtl/mode_pkg.sv - shared mode encodings, UART command bytes and tick helper
package mode_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_SR    = 2'd1,
    MODE_DHT   = 2'd2,
    MODE_WATCH = 2'd3
  } mode_e;

  localparam logic [7:0] CMD_SR_UC    = 8'h55;  // 'U'
  localparam logic [7:0] CMD_SR_LC    = 8'h75;  // 'u'
  localparam logic [7:0] CMD_DHT_UC   = 8'h44;  // 'D'
  localparam logic [7:0] CMD_DHT_LC   = 8'h64;  // 'd'
  localparam logic [7:0] CMD_WATCH_UC = 8'h57;  // 'W'
  localparam logic [7:0] CMD_WATCH_LC = 8'h77;  // 'w'
  localparam logic [7:0] CMD_OFF_UC   = 8'h58;  // 'X'
  localparam logic [7:0] CMD_OFF_LC   = 8'h78;  // 'x'

  function automatic int unsigned ms_to_ticks(input int unsigned clk_freq,
                                              input int unsigned period_ms);
    return (clk_freq / 1000) * period_ms;
  endfunction

endpackage

// File: rtl/period_trig.sv
// rtl/period_trig.sv - periodic / on-entry single-cycle trigger with busy hold-off
module period_trig #(
  parameter int unsigned PERIOD_TICKS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  input  logic busy,
  output logic trig
);

  localparam int unsigned CW = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD_TICKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          en_q, restart_q, pending_q, pending_d, trig_q;
  logic          tc, req;

  // en/restart arrive one cycle early (next-state view) so exit clears land on the exit edge
  always_comb begin
    tc        = en_q && (cnt_q == LAST);
    req       = restart_q || tc;
    trig      = en_q && !busy && !trig_q && (req || pending_q);
    cnt_d     = cnt_q + 1'b1;
    pending_d = pending_q;
    if (!en || !en_q || restart_q || tc) begin
      cnt_d = '0;
    end
    if (!en || trig) begin
      pending_d = 1'b0;
    end else if (req) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q      <= 1'b0;
      restart_q <= 1'b0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      trig_q    <= 1'b0;
    end else begin
      en_q      <= en;
      restart_q <= restart;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      trig_q    <= trig;
    end
  end

endmodule

// File: rtl/mode_ctrl.sv
// rtl/mode_ctrl.sv - application owner FSM: UART/button mode decode and trigger scheduling
module mode_ctrl
  import mode_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 100_000_000,
  parameter int unsigned SR_PERIOD_MS  = 100,
  parameter int unsigned DHT_PERIOD_MS = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       btn_mode,
  input  logic       sr_busy,
  input  logic       dht_busy,
  output logic       start_sr,
  output logic       start_dht,
  output logic       start_watch,
  output logic       sr_trig,
  output logic       dht_trig,
  output logic [1:0] mode
);

  localparam int unsigned SR_TICKS  = ms_to_ticks(CLK_FREQ, SR_PERIOD_MS);
  localparam int unsigned DHT_TICKS = ms_to_ticks(CLK_FREQ, DHT_PERIOD_MS);

  mode_e state_q, state_d, cmd_state;
  logic  cmd_hit;
  logic  sr_en, dht_en, sr_restart, dht_restart;
  logic  start_sr_q, start_dht_q, start_watch_q;

  always_comb begin
    cmd_hit   = 1'b0;
    cmd_state = MODE_OFF;
    if (rx_done) begin
      case (rx_data)
        CMD_SR_UC, CMD_SR_LC:       begin cmd_hit = 1'b1; cmd_state = MODE_SR;    end
        CMD_DHT_UC, CMD_DHT_LC:     begin cmd_hit = 1'b1; cmd_state = MODE_DHT;   end
        CMD_WATCH_UC, CMD_WATCH_LC: begin cmd_hit = 1'b1; cmd_state = MODE_WATCH; end
        CMD_OFF_UC, CMD_OFF_LC:     begin cmd_hit = 1'b1; cmd_state = MODE_OFF;   end
        default: ;
      endcase
    end

    // A recognised UART command shadows a coincident button pulse
    state_d = state_q;
    if (cmd_hit) begin
      state_d = cmd_state;
    end else if (btn_mode) begin
      case (state_q)
        MODE_OFF:   state_d = MODE_SR;
        MODE_SR:    state_d = MODE_DHT;
        MODE_DHT:   state_d = MODE_WATCH;
        MODE_WATCH: state_d = MODE_SR;
        default:    state_d = state_q;
      endcase
    end

    sr_en       = (state_d == MODE_SR);
    dht_en      = (state_d == MODE_DHT);
    sr_restart  = sr_en  && ((state_q != MODE_SR)  || cmd_hit);
    dht_restart = dht_en && ((state_q != MODE_DHT) || cmd_hit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= MODE_OFF;
      start_sr_q    <= 1'b0;
      start_dht_q   <= 1'b0;
      start_watch_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_sr_q    <= sr_en;
      start_dht_q   <= dht_en;
      start_watch_q <= (state_d == MODE_WATCH);
    end
  end

  period_trig #(.PERIOD_TICKS(SR_TICKS)) u_sr_trig (
    .clk     (clk),
    .rst     (rst),
    .en      (sr_en),
    .restart (sr_restart),
    .busy    (sr_busy),
    .trig    (sr_trig)
  );

  period_trig #(.PERIOD_TICKS(DHT_TICKS)) u_dht_trig (
    .clk     (clk),
    .rst     (rst),
    .en      (dht_en),
    .restart (dht_restart),
    .busy    (dht_busy),
    .trig    (dht_trig)
  );

  assign start_sr    = start_sr_q;
  assign start_dht   = start_dht_q;
  assign start_watch = start_watch_q;
  assign mode        = state_q;

endmodule

// File: tb/tb_mode_ctrl.sv
// tb/tb_mode_ctrl.sv - directed scoreboard bench for mode_ctrl
module tb_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       btn_mode = 1'b0;
  logic       sr_busy = 1'b0;
  logic       dht_busy = 1'b0;
  logic       start_sr, start_dht, start_watch, sr_trig, dht_trig;
  logic [1:0] mode;

  always #5 clk = ~clk;

  mode_ctrl #(.CLK_FREQ(1000), .SR_PERIOD_MS(10), .DHT_PERIOD_MS(1000)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .btn_mode    (btn_mode),
    .sr_busy     (sr_busy),
    .dht_busy    (dht_busy),
    .start_sr    (start_sr),
    .start_dht   (start_dht),
    .start_watch (start_watch),
    .sr_trig     (sr_trig),
    .dht_trig    (dht_trig),
    .mode        (mode)
  );

  typedef struct {
    string      tag;
    logic [1:0] mode;
    logic       srt;
    logic       dhtt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs for the current cycle were queued by the driver just after the rising edge
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, ".mode"},        {6'd0, mode},        {6'd0, e.mode});
      chk({e.tag, ".start_sr"},    {7'd0, start_sr},    {7'd0, e.mode == 2'd1});
      chk({e.tag, ".start_dht"},   {7'd0, start_dht},   {7'd0, e.mode == 2'd2});
      chk({e.tag, ".start_watch"}, {7'd0, start_watch}, {7'd0, e.mode == 2'd3});
      chk({e.tag, ".sr_trig"},     {7'd0, sr_trig},     {7'd0, e.srt});
      chk({e.tag, ".dht_trig"},    {7'd0, dht_trig},    {7'd0, e.dhtt});
    end
  end

  task automatic step(input logic rv, input logic [7:0] rd, input logic b,
                      input logic sbz, input logic dbz,
                      input logic [1:0] em, input logic est, input logic edt,
                      input string tag);
    rx_done  = rv;
    rx_data  = rd;
    btn_mode = b;
    sr_busy  = sbz;
    dht_busy = dbz;
    sb.push_back('{tag, em, est, edt});
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seq[5] = '{1, 2, 3, 1, 2};
    logic [1:0] em;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "reset");
    rst = 1'b0;

    for (int c = 0; c < 50; c++)
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "idle");

    // 'u' at 10, busy over the 21 expiry, 'X' at 45
    for (int c = 0; c < 50; c++) begin
      em = (c >= 11 && c <= 45) ? 2'd1 : 2'd0;
      step(c == 10 || c == 45, (c == 45) ? 8'h58 : 8'h75, 1'b0,
           c >= 21 && c <= 23, 1'b0, em,
           c == 11 || c == 24 || c == 31 || c == 41, 1'b0, "sr_period");
    end

    // button walk OFF->SR->DHT->WATCH->SR->DHT
    for (int c = 0; c <= 30; c++) begin
      em = (c == 0) ? 2'd0 : 2'(seq[(c - 1) / 6]);
      step(1'b0, 8'h00, (c % 6 == 0) && (c <= 24), 1'b0, 1'b0, em,
           c == 1 || c == 19, c == 7 || c == 25, "btn_walk");
    end

    // UART beats button; unrecognised byte lets the button through
    for (int c = 0; c < 10; c++) begin
      em = (c == 0) ? 2'd2 : (c <= 3) ? 2'd1 : (c <= 6) ? 2'd2 : 2'd3;
      step(c == 0 || c == 3 || c == 6,
           (c == 0) ? 8'h75 : (c == 3) ? 8'h44 : 8'h51,
           c == 3 || c == 6, 1'b0, 1'b0, em, c == 1, c == 4, "arb");
    end

    // DHT entry while busy, exit to OFF before busy falls; stray 'q' ignored
    for (int c = 0; c <= 12; c++) begin
      em = (c == 0) ? 2'd3 : (c <= 3) ? 2'd2 : 2'd0;
      step(c == 0 || c == 3 || c == 8,
           (c == 0) ? 8'h64 : (c == 3) ? 8'h78 : 8'h71,
           1'b0, 1'b0, c < 6, em, 1'b0, 1'b0, "dht_exit");
    end

    // manual re-trigger restarts the period, then 'w' and 'x'
    for (int c = 0; c <= 20; c++) begin
      em = (c == 0) ? 2'd0 : (c <= 16) ? 2'd1 : (c <= 18) ? 2'd3 : 2'd0;
      step(c == 0 || c == 4 || c == 16 || c == 18,
           (c == 0) ? 8'h55 : (c == 4) ? 8'h75 : (c == 16) ? 8'h77 : 8'h78,
           1'b0, 1'b0, 1'b0, em, c == 1 || c == 5 || c == 15, 1'b0, "retrig");
    end

    chk("scoreboard_drained", 8'(sb.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mode_ctrl.md
Name: mode_ctrl

Overview:
- Upstream controller for the output mux. Decides which application owns the FND, LED and TX resources: SR04 rangefinder, DHT11 sensor, or watch/stopwatch.
- Decodes mode commands from the UART receiver and from a debounced mode button.
- Drives mutually exclusive level selects (start_sr, start_dht, start_watch).
- Generates periodic single-cycle measurement triggers for the SR04 and DHT11 controllers.

Parameters:
- CLK_FREQ, 100_000_000, system clock in Hz.
- SR_PERIOD_MS, 100, SR04 auto-trigger period in ms.
- DHT_PERIOD_MS, 2000, DHT11 auto-trigger period in ms; must be ≥1000.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx_data  in  8  byte from UART receiver
- rx_done  in  1  one-cycle strobe; rx_data valid this cycle
- btn_mode  in  1  debounced one-cycle pulse; advance mode
- sr_busy  in  1  SR04 controller measuring
- dht_busy  in  1  DHT11 controller measuring
- start_sr  out  1  SR04 mode select (level)
- start_dht  out  1  DHT11 mode select (level)
- start_watch  out  1  watch mode select (level)
- sr_trig  out  1  one-cycle SR04 measurement start
- dht_trig  out  1  one-cycle DHT11 measurement start
- mode  out  2  current state encoding: OFF=0, SR=1, DHT=2, WATCH=3

Behaviour:
- Reset:
  - state OFF; all outputs 0.
  - Counters cleared; pending flags cleared.
  - Applies on the next clk edge, including mid-measurement and mid-period.
- FSM states are OFF, SR, DHT and WATCH. The select outputs are registered decodes of the state:
  - at most one select is high;
  - all selects are 0 in OFF.
- UART commands (case-insensitive ASCII):
  - 'U' → SR
  - 'D' → DHT
  - 'W' → WATCH
  - 'X' → OFF
  - Any other byte is ignored; no state change.
- btn_mode advances the mode: OFF→SR→DHT→WATCH→SR (OFF is left, never re-entered by the button).
- rx_done and btn_mode in the same cycle: the UART command wins and the button pulse is dropped. If the byte is unrecognised, the button is honoured.
- Latency: a command accepted at edge N changes state/selects/mode visible after edge N+1.
- Entering SR (or DHT) from another state:
  - the trig pulse is asserted on the first cycle in that state if the matching busy = 0;
  - if busy = 1, the pulse is held pending and issued on the first cycle busy = 0;
  - the period counter restarts from 0 at entry.
- Re-issuing the command of the current mode (e.g. 'U' while in SR) is a manual trigger: it behaves exactly as an entry (immediate or pending trig, counter restart). Selects do not toggle.
- Period counter (active only in its own mode):
  - counts clk cycles up to PERIOD_TICKS-1, where PERIOD_TICKS = CLK_FREQ/1000*PERIOD_MS;
  - at terminal count it wraps to 0 and requests a trig;
  - request with busy = 0 → trig pulse on that cycle; busy = 1 → pending.
- Pending:
  - at most one outstanding; further requests while pending are absorbed;
  - cleared when the trig is issued.
- Leaving a mode (including to OFF):
  - clears that mode's counter and pending flag the same edge;
  - no trig issued after exit;
  - a measurement already in flight is not aborted here.
- sr_trig can be high only while start_sr = 1; dht_trig only while start_dht = 1. Triggers are never high for two consecutive cycles.
- WATCH and OFF generate no triggers.
- Counter widths are $clog2(PERIOD_TICKS); no overflow is possible.

Decomposition:
- Package mode_pkg:
  - state encodings (MODE_OFF/SR/DHT/WATCH);
  - ASCII command constants (upper and lower case);
  - a ms-to-ticks constant function.
- Sub-module period_trig, instantiated twice (SR, DHT). Contents:
  - ports clk, rst, en, restart, busy, trig; parameter PERIOD_TICKS;
  - period counter, pending flag and entry/restart trigger.
- mode_ctrl holds the FSM, command decode and arbitration.

Test Plan:
- Bench parameters: CLK_FREQ=1000, SR_PERIOD_MS=10, DHT_PERIOD_MS=1000 (1 tick/ms).
- rst held 3 cycles, then released, no input → mode=0, all selects/trigs 0 for 50 cycles.
- rx 'u' at cycle 10, sr_busy=0:
  - mode=1 and start_sr=1 from cycle 11;
  - sr_trig pulses at cycle 11, then every 10 cycles (21, 31, …).
- In SR, sr_busy=1 over the expiry at cycle 21 until cycle 24 → no trig at 21; single sr_trig at cycle 24; next scheduled expiry still at cycle 31.
- Five btn_mode pulses from OFF → mode sequence 1, 2, 3, 1, 2; dht_trig once on DHT entry; no trig in WATCH.
- rx_done='D' and btn_mode in the same cycle from SR → mode=2, not 3; rx 'Q' with btn_mode → button honoured.
- In DHT with pending trig (dht_busy=1), rx 'x' → mode=0, all selects 0; no dht_trig after dht_busy falls.
